// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/aluop encodings and the ID/EX control bundle
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] aluop;
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: flags a load in EX whose destination is read by the ID instruction
module hazard_detect_unit #(
  parameter int RA_W = 5
) (
  input  logic            ex_valid,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  output logic            hazard
);

  // $0 is never a real dependency, so a load targeting it cannot stall
  assign hazard = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX register with load-use bubble insertion, flush squash and perf counters
module id_ex_pipe_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [1:0]        id_aluop,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [5:0]        id_funct,
  input  logic              hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic [1:0]        ex_aluop,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd,
  output logic [5:0]        ex_funct,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t id_ctrl, ex_ctrl;
  logic  hazard, advance, bubble, stall_ev, flush_ev;

  hazard_detect_unit #(.RA_W(RA_W)) u_hdu (
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl.memread),
    .ex_rt      (ex_rt),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .hazard     (hazard)
  );

  assign id_ctrl = '{aluop: id_aluop, regdst: id_regdst, alusrc: id_alusrc,
                     memtoreg: id_memtoreg, regwrite: id_regwrite, memread: id_memread,
                     memwrite: id_memwrite, branch: id_branch};

  // flush outranks hold (wrong-path work must leave EX); hold outranks the hazard
  assign advance  = flush | ~hold;
  assign bubble   = flush | hazard | ~id_valid;
  assign stall_ev = ~flush & ~hold & hazard;
  assign flush_ev = flush & id_valid;

  // PC and IF/ID freeze together on hold or a live hazard; a flush always lets fetch redirect
  always_comb begin
    pc_write   = flush | (~hold & ~hazard);
    ifid_write = flush | (~hold & ~hazard);
  end

  // ID->EX register bank; data fields follow ID even on bubbles since ex_valid masks them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= CTRL_BUBBLE;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_funct   <= '0;
    end else if (advance) begin
      ex_valid   <= ~bubble;
      ex_ctrl    <= bubble ? CTRL_BUBBLE : id_ctrl;
      ex_pc4     <= id_pc4;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_funct   <= id_funct;
    end
  end

  // saturating event counters: stick at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign ex_aluop    = ex_ctrl.aluop;
  assign ex_regdst   = ex_ctrl.regdst;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_branch   = ex_ctrl.branch;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed checks of capture, load-use bubble, flush, hold, reset and saturation
module tb_id_ex_pipe_reg;

  localparam logic [8:0] R_CTRL  = 9'b10_1_0_0_1_0_0_0;
  localparam logic [8:0] LW_CTRL = 9'b00_0_1_1_1_1_0_0;

  logic        clk = 1'b0, reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [1:0]  id_aluop = '0;
  logic        id_regdst = 0, id_alusrc = 0, id_memtoreg = 0, id_regwrite = 0;
  logic        id_memread = 0, id_memwrite = 0, id_branch = 0;
  logic [31:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [5:0]  id_funct = '0;
  logic        hold = 1'b0, flush = 1'b0;

  logic        ex_valid, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic        pc_write, ifid_write;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_valid, s_regdst, s_alusrc, s_memtoreg, s_regwrite, s_memread, s_memwrite, s_branch;
  logic [1:0]  s_aluop;
  logic [31:0] s_pc4, s_rs_data, s_rt_data, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [5:0]  s_funct;
  logic        s_pc_write, s_ifid_write;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  logic [8:0]  ex_c;
  assign ex_c = {ex_aluop, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch};

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_aluop(id_aluop), .id_regdst(id_regdst),
    .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .hold(hold), .flush(flush),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_funct(ex_funct), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_pipe_reg #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_aluop(id_aluop), .id_regdst(id_regdst),
    .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .hold(hold), .flush(flush),
    .ex_valid(s_valid), .ex_aluop(s_aluop), .ex_regdst(s_regdst), .ex_alusrc(s_alusrc),
    .ex_memtoreg(s_memtoreg), .ex_regwrite(s_regwrite), .ex_memread(s_memread),
    .ex_memwrite(s_memwrite), .ex_branch(s_branch), .ex_pc4(s_pc4), .ex_rs_data(s_rs_data),
    .ex_rt_data(s_rt_data), .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_funct(s_funct), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] funct, input logic [31:0] pc4);
    id_valid = 1'b1;
    {id_aluop, id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch} = c;
    id_rs = rs; id_rt = rt; id_rd = rd; id_funct = funct; id_pc4 = pc4;
    id_rs_data = 32'h1000 + 32'(rs);
    id_rt_data = 32'h2000 + 32'(rt);
    id_imm     = 32'h3000 + 32'(rd);
    #1;
  endtask

  initial begin
    #3;
    check("rst_valid", 64'(ex_valid), 0);
    check("rst_ctrl", 64'(ex_c), 0);
    check("rst_pcw", 64'(pc_write), 1);
    check("rst_cnt", 64'({stall_cnt, flush_cnt}), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1. add $3,$1,$2 then sub $5,$4,$6
    drive(R_CTRL, 1, 2, 3, 6'h20, 32'h4);
    tick();
    check("add_valid", 64'(ex_valid), 1);
    check("add_ctrl", 64'(ex_c), 64'(R_CTRL));
    check("add_regs", 64'({ex_rs, ex_rt, ex_rd, ex_funct}), 64'({5'd1, 5'd2, 5'd3, 6'h20}));
    check("add_data", {ex_rs_data, ex_rt_data}, {32'h1001, 32'h2002});
    check("add_imm_pc", {ex_imm, ex_pc4}, {32'h3003, 32'h4});
    drive(R_CTRL, 4, 6, 5, 6'h22, 32'h8);
    check("sub_pcw", 64'({pc_write, ifid_write}), 64'(2'b11));
    tick();
    check("sub_regs", 64'({ex_rs, ex_rt, ex_rd, ex_funct}), 64'({5'd4, 5'd6, 5'd5, 6'h22}));
    check("sub_pc", 64'(ex_pc4), 32'h8);
    check("t1_stall", 64'(stall_cnt), 0);

    // 2. lw $2,0($1) then add $4,$2,$3
    drive(LW_CTRL, 1, 2, 0, 6'h00, 32'hc);
    tick();
    check("lw_ctrl", 64'(ex_c), 64'(LW_CTRL));
    drive(R_CTRL, 2, 3, 4, 6'h20, 32'h10);
    check("lu_pcw", 64'({pc_write, ifid_write}), 0);
    tick();
    check("lu_bubble", 64'({ex_valid, ex_c}), 0);
    check("lu_stall", 64'(stall_cnt), 1);
    check("lu_pcw_after", 64'({pc_write, ifid_write}), 64'(2'b11));
    tick();
    check("lu_adv", 64'({ex_valid, ex_rd, ex_pc4[7:0]}), 64'({1'b1, 5'd4, 8'h10}));
    check("lu_stall2", 64'(stall_cnt), 1);

    // 3. loads to $0 and to an unrelated register never stall
    drive(LW_CTRL, 1, 0, 0, 6'h00, 32'h14);
    tick();
    drive(R_CTRL, 0, 0, 5, 6'h20, 32'h18);
    check("r0_pcw", 64'(pc_write), 1);
    tick();
    check("r0_adv", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd5}));
    drive(LW_CTRL, 1, 7, 0, 6'h00, 32'h1c);
    tick();
    drive(R_CTRL, 8, 9, 10, 6'h20, 32'h20);
    check("r7_pcw", 64'(pc_write), 1);
    tick();
    check("r7_adv", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd10}));
    check("t3_stall", 64'(stall_cnt), 1);

    // 4. flush coincident with a load-use hazard
    drive(LW_CTRL, 1, 2, 0, 6'h00, 32'h24);
    tick();
    drive(R_CTRL, 2, 3, 4, 6'h20, 32'h28);
    flush = 1'b1;
    #1;
    check("fl_pcw", 64'({pc_write, ifid_write}), 64'(2'b11));
    tick();
    flush = 1'b0;
    check("fl_bubble", 64'({ex_valid, ex_c}), 0);
    check("fl_cnt", 64'({stall_cnt, flush_cnt}), 64'({16'd1, 16'd1}));

    // 5. three-cycle hold mid-stream
    drive(R_CTRL, 1, 2, 11, 6'h20, 32'h30);
    tick();
    check("h_a", 64'(ex_rd), 11);
    drive(R_CTRL, 1, 2, 12, 6'h22, 32'h34);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("h_pcw", 64'({pc_write, ifid_write}), 0);
      tick();
      check("h_keep", 64'({ex_valid, ex_rd, ex_pc4[7:0]}), 64'({1'b1, 5'd11, 8'h30}));
    end
    hold = 1'b0;
    tick();
    check("h_b", 64'({ex_rd, ex_funct, ex_pc4[7:0]}), 64'({5'd12, 6'h22, 8'h34}));
    drive(R_CTRL, 1, 2, 13, 6'h20, 32'h38);
    tick();
    check("h_c", 64'({ex_rd, ex_pc4[7:0]}), 64'({5'd13, 8'h38}));

    // 6. reset pulsed while a hazard is pending
    drive(LW_CTRL, 1, 2, 0, 6'h00, 32'h3c);
    tick();
    drive(R_CTRL, 2, 3, 4, 6'h20, 32'h40);
    check("rs_pcw_pre", 64'(pc_write), 0);
    reset = 1'b1;
    #1;
    check("rs_async", 64'({ex_valid, ex_c}), 0);
    check("rs_cnt", 64'({stall_cnt, flush_cnt}), 0);
    check("rs_pcw", 64'({pc_write, ifid_write}), 64'(2'b11));
    @(negedge clk);
    reset = 1'b0;

    // five load-use hazards: 2-bit counter saturates, 16-bit keeps counting
    for (int i = 0; i < 5; i++) begin
      drive(LW_CTRL, 1, 2, 0, 6'h00, 32'h50);
      tick();
      drive(R_CTRL, 2, 3, 4, 6'h20, 32'h54);
      tick();
      tick();
    end
    check("sat_cnt", 64'(s_stall_cnt), 3);
    check("wide_cnt", 64'(stall_cnt), 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
